// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipeline_hazard_controller_if #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 32
);
   logic [REG_ADDR_WIDTH-1:0] id_rs1_address;
   logic [REG_ADDR_WIDTH-1:0] id_rs2_address;
   logic                      id_uses_rs1;
   logic                      id_uses_rs2;
   logic [REG_ADDR_WIDTH-1:0] ex_rd_address;
   logic                      ex_is_load;
   logic [1:0]                mem_next_pc_src;
   logic                      mem_ram_req;
   logic                      ram_ack;

   logic                      pc_wren;
   logic                      if_id_wren;
   logic                      id_ex_wren;
   logic                      ex_mem_wren;
   logic                      mem_wb_wren;
   logic                      if_id_clear_n;
   logic                      id_ex_clear_n;
   logic                      ex_mem_clear_n;
   logic                      mem_wait;
   logic                      mem_timeout_err;
   logic [CNT_WIDTH-1:0]      stall_count;

   modport master (
      output id_rs1_address, id_rs2_address, id_uses_rs1, id_uses_rs2,
             ex_rd_address, ex_is_load, mem_next_pc_src, mem_ram_req, ram_ack,
      input  pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren,
             if_id_clear_n, id_ex_clear_n, ex_mem_clear_n, mem_wait, mem_timeout_err,
             stall_count
   );

   modport slave (
      input  id_rs1_address, id_rs2_address, id_uses_rs1, id_uses_rs2,
             ex_rd_address, ex_is_load, mem_next_pc_src, mem_ram_req, ram_ack,
      output pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren,
             if_id_clear_n, id_ex_clear_n, ex_mem_clear_n, mem_wait, mem_timeout_err,
             stall_count
   );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Pipeline stall/flush sequencer: load-use bubbles, MEM-stage redirects and RAM wait freezes,
// with a RAM watchdog and a saturating stall-cycle counter.
module pipeline_hazard_controller #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned MEM_TIMEOUT    = 255,
  parameter int unsigned CNT_WIDTH      = 32
) (
   input logic                      clk,
   input logic                      reset_n,
   pipeline_hazard_controller_if.slave hz
);

   localparam int unsigned WaitW = $clog2(MEM_TIMEOUT);
   localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   state_e               state_q;
   logic [WaitW-1:0]     wait_cnt_q;
   logic                 timeout_err_q;
   logic [CNT_WIDTH-1:0] stall_count_q;

   logic force_release, mem_stall, redirect, load_use, rs1_hit, rs2_hit;

   assign force_release = (state_q == StWait) && (wait_cnt_q == WaitLast);
   assign mem_stall     = hz.mem_ram_req && !hz.ram_ack && !force_release;
   assign redirect      = (hz.mem_next_pc_src != 2'b00);
   assign rs1_hit       = hz.id_uses_rs1 && (hz.id_rs1_address == hz.ex_rd_address);
   assign rs2_hit       = hz.id_uses_rs2 && (hz.id_rs2_address == hz.ex_rd_address);
   assign load_use      = hz.ex_is_load && (hz.ex_rd_address != '0) && (rs1_hit || rs2_hit);

   // Priority: RAM freeze defers everything; a redirect squashes the load-use victim anyway.
   always_comb begin
      hz.pc_wren        = 1'b1;
      hz.if_id_wren     = 1'b1;
      hz.id_ex_wren     = 1'b1;
      hz.ex_mem_wren    = 1'b1;
      hz.mem_wb_wren    = 1'b1;
      hz.if_id_clear_n  = 1'b1;
      hz.id_ex_clear_n  = 1'b1;
      hz.ex_mem_clear_n = 1'b1;
      if (!reset_n) begin
         hz.pc_wren        = 1'b0;
         hz.if_id_wren     = 1'b0;
         hz.id_ex_wren     = 1'b0;
         hz.ex_mem_wren    = 1'b0;
         hz.mem_wb_wren    = 1'b0;
         hz.if_id_clear_n  = 1'b0;
         hz.id_ex_clear_n  = 1'b0;
         hz.ex_mem_clear_n = 1'b0;
      end else if (mem_stall) begin
         hz.pc_wren     = 1'b0;
         hz.if_id_wren  = 1'b0;
         hz.id_ex_wren  = 1'b0;
         hz.ex_mem_wren = 1'b0;
         hz.mem_wb_wren = 1'b0;
      end else if (redirect) begin
         hz.if_id_clear_n  = 1'b0;
         hz.id_ex_clear_n  = 1'b0;
         hz.ex_mem_clear_n = 1'b0;
      end else if (load_use) begin
         hz.pc_wren       = 1'b0;
         hz.if_id_wren    = 1'b0;
         hz.id_ex_clear_n = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         wait_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
         stall_count_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (mem_stall) begin
                  state_q    <= StWait;
                  wait_cnt_q <= WaitW'(1);
               end
            end
            StWait: begin
               if (mem_stall) begin
                  wait_cnt_q <= wait_cnt_q + WaitW'(1);
               end else begin
                  state_q    <= StIdle;
                  wait_cnt_q <= '0;
                  // Only flag the watchdog when it actually cut an unacknowledged access short.
                  if (force_release && hz.mem_ram_req && !hz.ram_ack) begin
                     timeout_err_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q    <= StIdle;
               wait_cnt_q <= '0;
            end
         endcase
         if (!hz.pc_wren && !(&stall_count_q)) begin
            stall_count_q <= stall_count_q + CNT_WIDTH'(1);
         end
      end
   end

   assign hz.mem_wait        = (state_q == StWait);
   assign hz.mem_timeout_err = timeout_err_q;
   assign hz.stall_count     = stall_count_q;

endmodule
